ball_motion_control: RTL
========================

# ball_motion_control

Parametrised successor to the development direction controller for the Pong ball. Four raw Go Board switches are synchronised, debounced and edge-detected. Each press either sets the ball direction or adjusts speed/reverses an axis, depending on mode. Collision pulses from the playfield logic reflect the ball directly. The block sits between the board switches/collision detector and the ball position updater, which consumes `o_HDir`, `o_VDir` and `o_Speed`.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: consecutive synchronised cycles a switch level must hold before it is accepted (10 ms at 25 MHz). Must be ≥2.
- `SPEED_W`, default 3: width of the speed field.
- `SPEED_INIT`, default 1: speed after reset. Must be ≤ `SPEED_MAX`.
- `SPEED_MAX`, default 7: saturation ceiling. Must be ≤ 2^`SPEED_W`−1.

Ports:
- `i_Clk` in 1: single system clock; all state on rising edge.
- `i_Rst_n` in 1: reset, asynchronous, active-low; asserts immediately, deasserted synchronously upstream.
- `i_Switch_1`..`i_Switch_4` in 1 each: raw asynchronous switch levels, high = pressed.
- `i_Mode` in 1: 0 = direction-set mode, 1 = speed/reverse mode.
- `i_Bounce_H` in 1: one-cycle pulse, ball hit a vertical wall or paddle.
- `i_Bounce_V` in 1: one-cycle pulse, ball hit the top or bottom wall.
- `o_HDir` out 1: RIGHT=0, LEFT=1.
- `o_VDir` out 1: DOWN=0, UP=1.
- `o_Speed` out `SPEED_W`: pixels per frame step; 0 = ball stopped.
- `o_Dir_Changed` out 1: one-cycle pulse after any change of `o_HDir` or `o_VDir`.

## Operation
Per-switch path:
- Two-flop synchroniser feeds a counter.
- The counter clears whenever the synchronised level equals the stable level. Otherwise it increments.
- When the counter is at `DEBOUNCE_LIMIT`−1 and the levels still differ, the stable level takes the synchronised level and the counter clears.
- A press is the rising edge of the stable level: a one-cycle pulse. Releases generate no event.

Mode 0 (direction-set). Presses map as follows:
- SW1 → LEFT/UP
- SW2 → LEFT/DOWN
- SW3 → RIGHT/UP
- SW4 → RIGHT/DOWN
- Simultaneous presses: the highest-numbered switch wins.

Mode 1 (speed/reverse):
- SW1: speed+1, saturating at `SPEED_MAX`.
- SW2: speed−1, saturating at 0.
- SW1 and SW2 pressed in the same cycle: no speed change.
- SW3: toggle HDir. SW4: toggle VDir. SW3 and SW4 are independent and may act in the same cycle.

Shared rules:
- `i_Mode` is sampled in the cycle the press pulse is high. A mode change while a switch is bouncing has no other effect.
- Bounce priority: `i_Bounce_H` toggles HDir and overrides any button action on the H axis in the same cycle. `i_Bounce_V` does the same for the V axis.
- Speed is unaffected by bounces.
- Reset values: `o_HDir`=0 (RIGHT), `o_VDir`=1 (UP), `o_Speed`=`SPEED_INIT`, `o_Dir_Changed`=0. All synchroniser, stable, counter and edge registers are 0.
- Reset mid-debounce discards the partial count. A switch held through reset is accepted as a press once the debounce completes after release of reset.

## Timing
- Let the switch rise be first sampled at edge 1.
- Synchroniser output is high after edge 2.
- Stable level updates at edge 2+`DEBOUNCE_LIMIT`.
- Press pulse is high in the following cycle.
- Direction/speed registers update at edge 3+`DEBOUNCE_LIMIT`.
- `o_Dir_Changed` is high for exactly the cycle after edge 4+`DEBOUNCE_LIMIT`.
- A glitch shorter than `DEBOUNCE_LIMIT` synchronised cycles produces no event.
- Bounce pulse high at edge k: the direction flips at edge k. `o_Dir_Changed` is high in the cycle after edge k+1.
- A bounce held high for n cycles toggles n times (the upstream contract is a single-cycle pulse).
- A write of the same direction value does not pulse `o_Dir_Changed`.

## Structure
- `pong_pkg` holds constants RIGHT, LEFT, UP, DOWN and MODE_DIR/MODE_SPEED. The position updater and paddle logic share these.
- One sub-module, `switch_debounce` (parameter `DEBOUNCE_LIMIT`; ports `i_Clk`, `i_Rst_n`, `i_Switch`, `o_Level`, `o_Press`), is instantiated four times.
- Direction, speed and change-detect logic live in the top module.

## Test plan
All scenarios use `DEBOUNCE_LIMIT`=4.
1. Reset then idle 20 cycles → `o_HDir`=0, `o_VDir`=1, `o_Speed`=1, `o_Dir_Changed` never high.
2. Mode 0: hold SW2 high 10 cycles → `o_HDir`=1 and `o_VDir`=0 at edge 7. `o_Dir_Changed` pulses once.
3. Mode 0: SW1 toggles every 2 cycles for 20 cycles, then goes low → no change on any output.
4. Mode 1: eight SW1 presses → speed 1→7, saturating. Then nine SW2 presses → speed 0 and stays 0. SW1+SW2 pressed together → speed unchanged.
5. Mode 1: SW3 press coinciding with `i_Bounce_H` on the same cycle → HDir toggles exactly once. A separate `i_Bounce_V` pulse → VDir flips at that edge and `o_Dir_Changed` follows one cycle later.
6. SW4 held; `i_Rst_n` pulsed low at count 2 → outputs return to reset values immediately. The press is registered 7 edges after `i_Rst_n` rises.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants: direction encodings and button-mode selectors.
package pong_pkg;
    localparam logic RIGHT      = 1'b0;
    localparam logic LEFT       = 1'b1;
    localparam logic DOWN       = 1'b0;
    localparam logic UP         = 1'b1;
    localparam logic MODE_DIR   = 1'b0;
    localparam logic MODE_SPEED = 1'b1;
endpackage

// File: rtl/switch_debounce.sv
// Synchronise, debounce and rising-edge-detect one raw board switch.
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press
);
    localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;

    logic             sync1, sync2, stable, stable_d;
    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            sync1    <= i_Switch;
            sync2    <= sync1;
            stable_d <= stable;
            // Any return to the stable level restarts the hold window.
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign o_Level = stable;
    assign o_Press = stable & ~stable_d;
endmodule

// File: rtl/ball_motion_control.sv
// Ball direction/speed control from debounced buttons and playfield collision pulses.
module ball_motion_control
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SPEED_W        = 3,
    parameter int SPEED_INIT     = 1,
    parameter int SPEED_MAX      = 7
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Switch_1,
    input  logic               i_Switch_2,
    input  logic               i_Switch_3,
    input  logic               i_Switch_4,
    input  logic               i_Mode,
    input  logic               i_Bounce_H,
    input  logic               i_Bounce_V,
    output logic               o_HDir,
    output logic               o_VDir,
    output logic [SPEED_W-1:0] o_Speed,
    output logic               o_Dir_Changed
);
    logic [3:0]         sw, press, level_unused;
    logic               next_h, next_v, h_q, v_q;
    logic [SPEED_W-1:0] next_speed;

    assign sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar i = 0; i < 4; i++) begin : g_sw
        switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db (
            .i_Clk    (i_Clk),
            .i_Rst_n  (i_Rst_n),
            .i_Switch (sw[i]),
            .o_Level  (level_unused[i]),
            .o_Press  (press[i])
        );
    end

    always_comb begin
        next_h     = o_HDir;
        next_v     = o_VDir;
        next_speed = o_Speed;
        if (i_Mode == MODE_DIR) begin
            if (press[3])      begin next_h = RIGHT; next_v = DOWN; end
            else if (press[2]) begin next_h = RIGHT; next_v = UP;   end
            else if (press[1]) begin next_h = LEFT;  next_v = DOWN; end
            else if (press[0]) begin next_h = LEFT;  next_v = UP;   end
        end else begin
            if (press[0] && !press[1] && (o_Speed < SPEED_W'(SPEED_MAX)))
                next_speed = o_Speed + SPEED_W'(1);
            if (press[1] && !press[0] && (o_Speed != '0))
                next_speed = o_Speed - SPEED_W'(1);
            if (press[2]) next_h = ~o_HDir;
            if (press[3]) next_v = ~o_VDir;
        end
        // Collisions win over any button action on the same axis.
        if (i_Bounce_H) next_h = ~o_HDir;
        if (i_Bounce_V) next_v = ~o_VDir;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_HDir        <= RIGHT;
            o_VDir        <= UP;
            o_Speed       <= SPEED_W'(SPEED_INIT);
            h_q           <= RIGHT;
            v_q           <= UP;
            o_Dir_Changed <= 1'b0;
        end else begin
            o_HDir        <= next_h;
            o_VDir        <= next_v;
            o_Speed       <= next_speed;
            h_q           <= o_HDir;
            v_q           <= o_VDir;
            o_Dir_Changed <= (o_HDir != h_q) || (o_VDir != v_q);
        end
    end
endmodule
